// File: rtl/prs_conv_err_chain.sv
// PRBS-15 source -> K=7 rate-1/2 convolutional encoder -> symbol error injector.
// Three registered stages in series, one word out per input request.
module prs_conv_err_chain #(
  parameter int ERR_W = 11
) (
  input  logic             clk,
  input  logic             nRESET,
  input  logic             i_vld,
  input  logic             i_enable,
  input  logic [ERR_W-1:0] i_first_err,
  input  logic [ERR_W-1:0] i_err_rate,
  output logic             prs_vld,
  output logic             prs_sym,
  output logic             enc_vld,
  output logic [1:0]       enc_word,
  output logic             o_vld,
  output logic [1:0]       o_word
);

  typedef enum logic {
    FIRST,
    PERIODIC
  } mode_t;

  logic [14:0]      s;
  logic [5:0]       sr;
  logic [6:0]       u;
  mode_t            mode;
  mode_t            mode_nx;
  logic [ERR_W-1:0] cnt;
  logic [ERR_W-1:0] cnt_nx;
  logic [ERR_W-1:0] cnt_inc;
  logic             inv;

  assign u       = {prs_sym, sr};
  assign cnt_inc = cnt + ERR_W'(1);

  // PRBS-15 generator, x^15+x^14+1, advances only on request
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      s       <= 15'h7FFF;
      prs_sym <= 1'b0;
      prs_vld <= 1'b0;
    end else begin
      prs_vld <= i_vld;
      if (i_vld) begin
        prs_sym <= s[14];
        s       <= {s[13:0], s[14] ^ s[13]};
      end
    end
  end

  // Convolutional encoder, G1=171 octal, G2=133 octal, newest bit is tap 6
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      sr       <= '0;
      enc_word <= 2'b00;
      enc_vld  <= 1'b0;
    end else begin
      enc_vld <= prs_vld;
      if (prs_vld) begin
        enc_word <= {^(u & 7'o171), ^(u & 7'o133)};
        sr       <= {prs_sym, sr[5:1]};
      end
    end
  end

  // Error placement: first error at a fixed index, then every i_err_rate words
  always_comb begin
    mode_nx = mode;
    cnt_nx  = cnt;
    inv     = 1'b0;
    if (!i_enable) begin
      mode_nx = FIRST;
      cnt_nx  = '0;
    end else if (enc_vld) begin
      unique case (mode)
        FIRST: begin
          if (cnt == i_first_err) begin
            inv     = 1'b1;
            cnt_nx  = '0;
            mode_nx = PERIODIC;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        PERIODIC: begin
          if (i_err_rate != '0 && cnt_inc == i_err_rate) begin
            inv    = 1'b1;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        default: begin
          mode_nx = FIRST;
          cnt_nx  = '0;
        end
      endcase
    end
  end

  // Error injector state and output register
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      mode   <= FIRST;
      cnt    <= '0;
      o_vld  <= 1'b0;
      o_word <= 2'b00;
    end else begin
      mode  <= mode_nx;
      cnt   <= cnt_nx;
      o_vld <= enc_vld;
      if (enc_vld) begin
        o_word <= inv ? ~enc_word : enc_word;
      end
    end
  end

endmodule

// File: tb/tb_prs_conv_err_chain.sv
// Bench for prs_conv_err_chain: stream-level reference model plus
// literal checks on PRS seed, encoder impulse and error placement.
module tb_prs_conv_err_chain;

  localparam int EW  = 11;
  localparam int PER = 32767;

  logic          clk = 1'b0;
  logic          nRESET = 1'b0;
  logic          i_vld = 1'b0;
  logic          i_enable = 1'b0;
  logic [EW-1:0] i_first_err = '0;
  logic [EW-1:0] i_err_rate = '0;
  logic          prs_vld, prs_sym, enc_vld, o_vld;
  logic [1:0]    enc_word, o_word;

  int checks = 0;
  int failures = 0;

  bit pbits[PER+64];

  prs_conv_err_chain #(.ERR_W(EW)) dut (
    .clk(clk), .nRESET(nRESET), .i_vld(i_vld),
    .i_enable(i_enable), .i_first_err(i_first_err),
    .i_err_rate(i_err_rate), .prs_vld(prs_vld),
    .prs_sym(prs_sym), .enc_vld(enc_vld),
    .enc_word(enc_word), .o_vld(o_vld), .o_word(o_word)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [1:0] act, logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc_of_u(logic [6:0] u);
    return {^(u & 7'o171), ^(u & 7'o133)};
  endfunction

  function automatic bit pbit(int n);
    return pbits[n % PER];
  endfunction

  // coded word m is a function of PRS bits m..m-6 (bits before 0 are zero)
  function automatic logic [1:0] enc_m(int m);
    logic [6:0] u;
    u = '0;
    for (int j = 0; j < 7; j++)
      if (m - j >= 0) u[6-j] = pbit(m - j);
    return enc_of_u(u);
  endfunction

  // k = valid-word index since enable
  function automatic bit hit(int k, int f, int r);
    if (k == f) return 1'b1;
    if (r != 0 && k > f && ((k - f) % r) == 0) return 1'b1;
    return 1'b0;
  endfunction

  // reference model: expected outputs after each edge
  logic       e_pv = 0, e_ps = 0, e_ev = 0, e_ov = 0;
  logic [1:0] e_ew = 0, e_ow = 0;
  int         n_bits = 0, m_words = 0, k_err = 0;
  bit         live = 0;

  always @(posedge clk) begin : model
    logic       npv, nps, nev, nov;
    logic [1:0] nw, now;
    if (!nRESET) begin
      n_bits = 0; m_words = 0; k_err = 0;
      e_pv = 0; e_ps = 0; e_ev = 0;
      e_ew = 0; e_ov = 0; e_ow = 0;
    end else begin
      if (!i_enable) k_err = 0;
      nov = e_ev;
      now = e_ow;
      if (e_ev) begin
        now = e_ew;
        if (i_enable) begin
          if (hit(k_err, int'(i_first_err), int'(i_err_rate)))
            now = ~e_ew;
          k_err++;
        end
      end
      nev = e_pv;
      nw  = e_ew;
      if (e_pv) begin
        nw = enc_m(m_words);
        m_words++;
      end
      npv = i_vld;
      nps = e_ps;
      if (i_vld) begin
        nps = pbit(n_bits);
        n_bits++;
      end
      e_pv = npv; e_ps = nps; e_ev = nev;
      e_ew = nw;  e_ov = nov; e_ow = now;
    end
    live = 1;
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (live) begin
      chk("prs_vld", {1'b0, prs_vld}, {1'b0, e_pv});
      chk("prs_sym", {1'b0, prs_sym}, {1'b0, e_ps});
      chk("enc_vld", {1'b0, enc_vld}, {1'b0, e_ev});
      chk("enc_word", enc_word, e_ew);
      chk("o_vld", {1'b0, o_vld}, {1'b0, e_ov});
      chk("o_word", o_word, e_ow);
    end
  end

  // stream capture
  bit         pq[$];
  logic [1:0] eq[$];
  logic [1:0] oq[$];
  logic [1:0] cont[$];

  always @(negedge clk) begin
    if (prs_vld === 1'b1) pq.push_back(prs_sym);
    if (enc_vld === 1'b1) eq.push_back(enc_word);
    if (o_vld === 1'b1)   oq.push_back(o_word);
  end

  task automatic clr();
    pq.delete(); eq.delete(); oq.delete();
  endtask

  task automatic do_reset(int ncyc);
    @(negedge clk);
    nRESET = 1'b0;
    i_vld  = 1'b0;
    repeat (ncyc) @(negedge clk);
    nRESET = 1'b1;
  endtask

  task automatic send(int nw, int gap);
    for (int i = 0; i < nw; i++) begin
      i_vld = 1'b1;
      @(negedge clk);
      i_vld = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic drain();
    i_vld = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic [1:0] imp [7];
    int ninv;
    imp = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};

    for (int i = 0; i < 15; i++) pbits[i] = 1'b1;
    for (int i = 0; i + 15 < PER + 64; i++)
      pbits[i+15] = pbits[i] ^ pbits[i+1];

    // model pins: seed run, period, encoder impulse response
    chk("pin_bit15", {1'b0, pbits[15]}, 2'b00);
    for (int i = 0; i < 16; i++)
      chk("pin_period", {1'b0, pbits[PER+i]}, {1'b0, pbits[i]});
    for (int t = 0; t < 7; t++)
      chk("pin_impulse", enc_of_u(7'b1000000 >> t), imp[t]);

    // PRS seed
    do_reset(2);
    clr();
    chk("rst_o_vld", {1'b0, o_vld}, 2'b00);
    chk("rst_o_word", o_word, 2'b00);
    send(20, 0);
    drain();
    if (pq.size() != 20) begin
      chk("seed_count", 2'(pq.size() > 3 ? 3 : pq.size()), 2'b00);
    end else begin
      for (int i = 0; i < 20; i++)
        if (i < 16)
          chk("seed_bit", {1'b0, pq[i]}, (i < 15) ? 2'b01 : 2'b00);
    end

    // disabled: 1000 words pass through
    send(1000, 0);
    drain();

    // error placement F=4 R=30
    do_reset(1);
    clr();
    i_first_err = 11'd4;
    i_err_rate  = 11'd30;
    i_enable    = 1'b1;
    send(200, 0);
    drain();
    chk("place_cnt", (oq.size() == 200 && eq.size() == 200) ? 2'b01 : 2'b00, 2'b01);
    if (oq.size() == 200 && eq.size() == 200) begin
      for (int i = 0; i < 200; i++) begin
        chk("place_word", oq[i],
            (i >= 4 && (i - 4) % 30 == 0) ? ~eq[i] : eq[i]);
        cont.push_back(oq[i]);
      end
    end

    // first error only
    do_reset(1);
    clr();
    i_first_err = 11'd0;
    i_err_rate  = 11'd0;
    send(100, 0);
    drain();
    ninv = 0;
    for (int i = 0; i < oq.size() && i < eq.size(); i++)
      if (oq[i] !== eq[i]) ninv++;
    chk("rate0_ninv", 2'(ninv > 3 ? 3 : ninv), 2'b01);
    if (oq.size() > 0 && eq.size() > 0)
      chk("rate0_w0", oq[0], ~eq[0]);

    // sparse valid, one in 64
    do_reset(1);
    clr();
    i_first_err = 11'd4;
    i_err_rate  = 11'd30;
    send(40, 63);
    drain();
    chk("sparse_cnt", (oq.size() == 40) ? 2'b01 : 2'b00, 2'b01);
    for (int i = 0; i < 40 && i < oq.size() && i < cont.size(); i++)
      chk("sparse_word", oq[i], cont[i]);

    // mid-stream reset
    do_reset(1);
    clr();
    send(100, 0);
    i_vld  = 1'b1;
    nRESET = 1'b0;
    @(negedge clk);
    nRESET = 1'b1;
    i_vld  = 1'b0;
    chk("mrst_vlds", {o_vld | enc_vld, prs_vld}, 2'b00);
    chk("mrst_words", o_word | enc_word, 2'b00);
    clr();
    send(100, 0);
    drain();
    chk("mrst_cnt", (oq.size() == 100) ? 2'b01 : 2'b00, 2'b01);
    for (int i = 0; i < 100 && i < oq.size() && i < cont.size(); i++)
      chk("mrst_word", oq[i], cont[i]);

    // randomized segments against the model
    for (int seg = 0; seg < 8; seg++) begin
      i_enable = 1'b0;
      drain();
      i_first_err = EW'($urandom_range(0, 12));
      i_err_rate  = EW'($urandom_range(0, 7));
      i_enable    = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 300; c++) begin
        i_vld  = ($urandom_range(0, 2) != 0);
        nRESET = ($urandom_range(0, 149) != 0);
        @(negedge clk);
      end
      nRESET = 1'b1;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
